// File: rtl/sdram_arb.sv
// Two-port arbiter/sequencer sharing the single sdram_top request port between a CPU and a DMA master.
// Optional watchdog on the downstream handshake is enabled with `define SDARB_TIMEOUT_EN.
module sdram_arb #(
    parameter int TMO_W = 8
) (
    input  logic        clk_p,
    input  logic        rst_n,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [1:0]  m0_sel,
    input  logic [20:0] m0_adr,
    input  logic [15:0] m0_dat_i,
    output logic [15:0] m0_dat_o,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [1:0]  m1_sel,
    input  logic [20:0] m1_adr,
    input  logic [15:0] m1_dat_i,
    output logic [15:0] m1_dat_o,
    output logic        m1_ack,
    output logic        m1_err,
    input  logic        sd_ready,
    output logic        sd_wr_req,
    output logic        sd_rd_req,
    input  logic        sd_wr_ack,
    input  logic        sd_rd_ack,
    output logic [1:0]  sd_be,
    output logic [21:0] sd_adr,
    output logic [15:0] sd_dout,
    input  logic [15:0] sd_din,
    output logic [1:0]  dqm
);

    typedef enum logic [1:0] {IDLE, REQ, ACK, TMO} state_t;

    state_t      state;
    logic        gnt;
    logic        last;
    logic        we_r;
    logic        ack_r;
    logic        nxt_gnt;
    logic        gnt_stb;
    logic        sd_done;
    logic        tmo_hit;
    logic        s_we;
    logic [1:0]  s_sel;
    logic [20:0] s_adr;
    logic [15:0] s_dat;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        nxt_gnt = m1_stb;
        if (m0_stb && m1_stb)
            nxt_gnt = ~last;
        s_we  = nxt_gnt ? m1_we    : m0_we;
        s_sel = nxt_gnt ? m1_sel   : m0_sel;
        s_adr = nxt_gnt ? m1_adr   : m0_adr;
        s_dat = nxt_gnt ? m1_dat_i : m0_dat_i;
    end

    assign gnt_stb = gnt ? m1_stb : m0_stb;
    assign sd_done = we_r ? sd_wr_ack : sd_rd_ack;
    assign m0_ack  = ack_r & ~gnt & m0_stb;
    assign m1_ack  = ack_r &  gnt & m1_stb;

`ifdef SDARB_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == {TMO_W{1'b1}});
    assign m0_err  = m0_ack & (state == TMO);
    assign m1_err  = m1_ack & (state == TMO);

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if (state == REQ && !tmo_hit)
            tmo_cnt <= tmo_cnt + 1'b1;
        else
            tmo_cnt <= '0;
    end
`else
    assign tmo_hit = 1'b0;
    assign m0_err  = 1'b0;
    assign m1_err  = 1'b0;
`endif

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            last      <= 1'b1;
            we_r      <= 1'b0;
            ack_r     <= 1'b0;
            sd_wr_req <= 1'b0;
            sd_rd_req <= 1'b0;
            sd_be     <= 2'b00;
            dqm       <= 2'b00;
            sd_adr    <= '0;
            sd_dout   <= '0;
            m0_dat_o  <= '0;
            m1_dat_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sd_ready && (m0_stb || m1_stb)) begin
                        gnt       <= nxt_gnt;
                        last      <= nxt_gnt;
                        we_r      <= s_we;
                        sd_wr_req <= s_we;
                        sd_rd_req <= ~s_we;
                        sd_be     <= s_we ? s_sel : 2'b11;
                        dqm       <= s_we ? ~s_sel : 2'b00;
                        sd_adr    <= {1'b0, s_adr};
                        sd_dout   <= s_dat;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    // An aborted master skips ACK so it never sees a stale acknowledge.
                    if (sd_done || tmo_hit) begin
                        sd_wr_req <= 1'b0;
                        sd_rd_req <= 1'b0;
                        if (!we_r) begin
                            if (gnt)
                                m1_dat_o <= sd_done ? sd_din : 16'hFFFF;
                            else
                                m0_dat_o <= sd_done ? sd_din : 16'hFFFF;
                        end
                        ack_r <= gnt_stb;
                        if (!gnt_stb)
                            state <= IDLE;
                        else
                            state <= sd_done ? ACK : TMO;
                    end
                end
                ACK, TMO: begin
                    if (!gnt_stb) begin
                        ack_r <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
